// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: op encoding, exception causes, FSM states.
package mem_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LH   = 4'd2,
    LW   = 4'd3,
    LBU  = 4'd4,
    LHU  = 4'd5,
    SB   = 4'd6,
    SH   = 4'd7,
    SW   = 4'd8
  } mem_op_t;

  localparam logic [1:0] CAUSE_LOAD_MISALIGN  = 2'd0;
  localparam logic [1:0] CAUSE_STORE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_LOAD_TIMEOUT   = 2'd2;
  localparam logic [1:0] CAUSE_STORE_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_WAIT_RVALID
  } state_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic is_half(mem_op_t op);
    return op inside {LH, LHU, SH};
  endfunction

  function automatic logic is_word(mem_op_t op);
    return op inside {LW, SW};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / lane replication and load extraction / extension.
module lsu_align
  import mem_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o     = 4'b0000;
    wdata_o  = 32'h0;
    rdata_o  = 32'h0;
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (op_i)
      SB: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SH: begin
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SW: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      LB: begin
        be_o    = 4'b0001 << off_i;
        rdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      LBU: begin
        be_o    = 4'b0001 << off_i;
        rdata_o = {24'h0, byte_sel};
      end
      LH: begin
        be_o    = 4'b0011 << off_i;
        rdata_o = {{16{half_sel[15]}}, half_sel};
      end
      LHU: begin
        be_o    = 4'b0011 << off_i;
        rdata_o = {16'h0, half_sel};
      end
      LW: begin
        be_o    = 4'b1111;
        rdata_o = rdata_i;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage (EX -> MEM -> WB) driving a req/gnt/rvalid data bus.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_mem_op_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_we_i,
  input  logic [31:0] ex_pc_i,
  output logic        hold_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_rd_we_o,
  output logic [31:0] wb_wdata_o,
  output logic        exc_valid_o,
  output logic [1:0]  exc_cause_o,
  output logic [31:0] exc_pc_o,
  output logic [31:0] exc_tval_o
);

  logic        occ_q, occ_d;
  mem_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  logic        wb_valid_q, wb_valid_d, wb_rd_we_q, wb_rd_we_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d, cause_now;
  logic [31:0] exc_pc_q, exc_pc_d, exc_tval_q, exc_tval_d;

  logic        ld, st, mem, misalign, done, exc_now, timeout_hit, req;
  logic [31:0] eff_addr, load_data, lane_wdata;
  logic [3:0]  lane_be;

  assign ld  = is_load(op_q);
  assign st  = is_store(op_q);
  assign mem = ld | st;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (is_half(op_q) && addr_q[0]) || (is_word(op_q) && (addr_q[1:0] != 2'b00));
  assign eff_addr = addr_q;
`else
  assign misalign = 1'b0;
  assign eff_addr = is_word(op_q) ? {addr_q[31:2], 2'b00} :
                    is_half(op_q) ? {addr_q[31:1], 1'b0} : addr_q;
`endif

  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q != ST_IDLE) && (cnt_q == TIMEOUT_CYC);

  lsu_align u_align (
    .op_i    (op_q),
    .off_i   (eff_addr[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (data_rdata_i),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (load_data)
  );

  // Bus FSM; a timeout drops the request in the same cycle it fires.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    done      = 1'b0;
    exc_now   = 1'b0;
    cause_now = CAUSE_LOAD_MISALIGN;
    if (occ_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!mem) begin
            done = 1'b1;
          end else if (misalign) begin
            done      = 1'b1;
            exc_now   = 1'b1;
            cause_now = ld ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
          end else begin
            req   = 1'b1;
            cnt_d = 32'd0;
            if (!data_gnt_i)  state_d = ST_WAIT_GNT;
            else if (ld)      state_d = ST_WAIT_RVALID;
            else              done    = 1'b1;
          end
        end
        ST_WAIT_GNT: begin
          if (timeout_hit) begin
            done      = 1'b1;
            exc_now   = 1'b1;
            cause_now = ld ? CAUSE_LOAD_TIMEOUT : CAUSE_STORE_TIMEOUT;
            state_d   = ST_IDLE;
            cnt_d     = 32'd0;
          end else begin
            req = 1'b1;
            if (data_gnt_i) begin
              cnt_d   = 32'd0;
              state_d = ld ? ST_WAIT_RVALID : ST_IDLE;
              done    = !ld;
            end else if (TIMEOUT_CYC != 0) begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        ST_WAIT_RVALID: begin
          if (timeout_hit) begin
            done      = 1'b1;
            exc_now   = 1'b1;
            cause_now = CAUSE_LOAD_TIMEOUT;
            state_d   = ST_IDLE;
            cnt_d     = 32'd0;
          end else if (data_rvalid_i) begin
            done    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
          end else if (TIMEOUT_CYC != 0) begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 32'd0;
        end
      endcase
    end else begin
      state_d = ST_IDLE;
      cnt_d   = 32'd0;
    end
  end

  assign hold_o       = occ_q && !done;
  assign data_req_o   = req;
  assign data_we_o    = req && st;
  assign data_be_o    = req ? lane_be : 4'b0000;
  assign data_addr_o  = req ? {eff_addr[31:2], 2'b00} : 32'h0;
  assign data_wdata_o = req ? lane_wdata : 32'h0;

  always_comb begin
    occ_d   = occ_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    pc_d    = pc_q;
    if (!hold_o) begin
      occ_d   = ex_valid_i;
      op_d    = ex_valid_i ? mem_op_t'(ex_mem_op_i) : NONE;
      addr_d  = ex_valid_i ? ex_alu_result_i : 32'h0;
      wdata_d = ex_valid_i ? ex_wdata_i : 32'h0;
      rd_d    = ex_valid_i ? ex_rd_addr_i : 5'd0;
      rd_we_d = ex_valid_i && ex_rd_we_i;
      pc_d    = ex_valid_i ? ex_pc_i : 32'h0;
    end
  end

  // Write-back and exception packets are registered one cycle after done.
  always_comb begin
    wb_valid_d   = done;
    wb_rd_addr_d = done ? rd_q : 5'd0;
    wb_rd_we_d   = done && rd_we_q && !exc_now && !st;
    wb_wdata_d   = 32'h0;
    if (done && !exc_now && !st) wb_wdata_d = ld ? load_data : addr_q;
    exc_valid_d  = exc_now;
    exc_cause_d  = exc_now ? cause_now : 2'd0;
    exc_pc_d     = exc_now ? pc_q : 32'h0;
    exc_tval_d   = exc_now ? addr_q : 32'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q        <= 1'b0;
      op_q         <= NONE;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rd_q         <= 5'd0;
      rd_we_q      <= 1'b0;
      pc_q         <= 32'h0;
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_addr_q <= 5'd0;
      wb_rd_we_q   <= 1'b0;
      wb_wdata_q   <= 32'h0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= 2'd0;
      exc_pc_q     <= 32'h0;
      exc_tval_q   <= 32'h0;
    end else begin
      occ_q        <= occ_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      pc_q         <= pc_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_we_q   <= wb_rd_we_d;
      wb_wdata_q   <= wb_wdata_d;
      exc_valid_q  <= exc_valid_d;
      exc_cause_q  <= exc_cause_d;
      exc_pc_q     <= exc_pc_d;
      exc_tval_q   <= exc_tval_d;
    end
  end

  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_addr_o = wb_rd_addr_q;
  assign wb_rd_we_o   = wb_rd_we_q;
  assign wb_wdata_o   = wb_wdata_q;
  assign exc_valid_o  = exc_valid_q;
  assign exc_cause_o  = exc_cause_q;
  assign exc_pc_o     = exc_pc_q;
  assign exc_tval_o   = exc_tval_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT_CYC=4); follows MEM_MISALIGN_TRAP_EN for the misalign step.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_alu_result, ex_wdata, ex_pc;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;
  logic        hold, data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        wb_valid, wb_rd_we;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_wdata;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_valid_i      (ex_valid),
    .ex_mem_op_i     (ex_mem_op),
    .ex_alu_result_i (ex_alu_result),
    .ex_wdata_i      (ex_wdata),
    .ex_rd_addr_i    (ex_rd_addr),
    .ex_rd_we_i      (ex_rd_we),
    .ex_pc_i         (ex_pc),
    .hold_o          (hold),
    .data_req_o      (data_req),
    .data_we_o       (data_we),
    .data_be_o       (data_be),
    .data_addr_o     (data_addr),
    .data_wdata_o    (data_wdata),
    .data_gnt_i      (data_gnt),
    .data_rvalid_i   (data_rvalid),
    .data_rdata_i    (data_rdata),
    .wb_valid_o      (wb_valid),
    .wb_rd_addr_o    (wb_rd_addr),
    .wb_rd_we_o      (wb_rd_we),
    .wb_wdata_o      (wb_wdata),
    .exc_valid_o     (exc_valid),
    .exc_cause_o     (exc_cause),
    .exc_pc_o        (exc_pc),
    .exc_tval_o      (exc_tval)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] rd, input logic we,
                               input logic [31:0] pc);
    ex_valid      = v;
    ex_mem_op     = op;
    ex_alu_result = addr;
    ex_wdata      = wd;
    ex_rd_addr    = rd;
    ex_rd_we      = we;
    ex_pc         = pc;
  endtask

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic toSample();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b1;
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    data_rdata  = 32'h0;
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    toSample();
    checkOutput("rst_hold", 32'(hold), 32'd0);
    checkOutput("rst_req", 32'(data_req), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_exc_valid", 32'(exc_valid), 32'd0);
    checkOutput("rst_wb_wdata", wb_wdata, 32'h0);
    toDrive();
    rst = 1'b0;

    $display("[TB] SW 0x100, grant same cycle");
    toDrive();
    applyStimulus(1'b1, 4'd8, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 32'h1000);
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    data_gnt = 1'b1;
    toSample();
    checkOutput("sw_req", 32'(data_req), 32'd1);
    checkOutput("sw_we", 32'(data_we), 32'd1);
    checkOutput("sw_be", 32'(data_be), 32'hF);
    checkOutput("sw_addr", data_addr, 32'h100);
    checkOutput("sw_wdata", data_wdata, 32'hDEADBEEF);
    checkOutput("sw_hold", 32'(hold), 32'd0);
    toDrive();
    data_gnt = 1'b0;
    toSample();
    checkOutput("sw_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("sw_wb_rd_we", 32'(wb_rd_we), 32'd0);
    toDrive();
    toSample();
    checkOutput("sw_wb_valid_once", 32'(wb_valid), 32'd0);

    $display("[TB] LB 0x203, grant after 2 cycles");
    toDrive();
    applyStimulus(1'b1, 4'd1, 32'h203, 32'h0, 5'd3, 1'b1, 32'h1004);
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    toSample();
    checkOutput("lb_hold_1", 32'(hold), 32'd1);
    checkOutput("lb_req_1", 32'(data_req), 32'd1);
    checkOutput("lb_addr_1", data_addr, 32'h200);
    toDrive();
    toSample();
    checkOutput("lb_hold_2", 32'(hold), 32'd1);
    checkOutput("lb_addr_2", data_addr, 32'h200);
    toDrive();
    data_gnt = 1'b1;
    toSample();
    checkOutput("lb_hold_3", 32'(hold), 32'd1);
    checkOutput("lb_req_3", 32'(data_req), 32'd1);
    toDrive();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h80FF_0000;
    toSample();
    checkOutput("lb_hold_rvalid", 32'(hold), 32'd0);
    checkOutput("lb_req_rvalid", 32'(data_req), 32'd0);
    toDrive();
    data_rvalid = 1'b0;
    toSample();
    checkOutput("lb_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("lb_wb_wdata", wb_wdata, 32'hFFFFFF80);
    checkOutput("lb_wb_rd", 32'(wb_rd_addr), 32'd3);
    checkOutput("lb_wb_rd_we", 32'(wb_rd_we), 32'd1);

    $display("[TB] LHU 0x202");
    toDrive();
    applyStimulus(1'b1, 4'd5, 32'h202, 32'h0, 5'd4, 1'b1, 32'h1008);
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    data_gnt = 1'b1;
    toSample();
    checkOutput("lhu_req", 32'(data_req), 32'd1);
    checkOutput("lhu_hold", 32'(hold), 32'd1);
    toDrive();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h8001_1234;
    toSample();
    checkOutput("lhu_hold_rvalid", 32'(hold), 32'd0);
    toDrive();
    data_rvalid = 1'b0;
    toSample();
    checkOutput("lhu_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("lhu_wb_wdata", wb_wdata, 32'h0000_8001);

    $display("[TB] SH 0x202");
    toDrive();
    applyStimulus(1'b1, 4'd7, 32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 32'h100C);
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    data_gnt = 1'b1;
    toSample();
    checkOutput("sh_be", 32'(data_be), 32'hC);
    checkOutput("sh_wdata", data_wdata, 32'hABCDABCD);
    checkOutput("sh_addr", data_addr, 32'h200);
    checkOutput("sh_we", 32'(data_we), 32'd1);
    checkOutput("sh_hold", 32'(hold), 32'd0);
    toDrive();
    data_gnt = 1'b0;
    toSample();
    checkOutput("sh_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("sh_wb_rd_we", 32'(wb_rd_we), 32'd0);

    $display("[TB] LW 0x300, grant never arrives");
    toDrive();
    applyStimulus(1'b1, 4'd3, 32'h300, 32'h0, 5'd6, 1'b1, 32'h1010);
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    toSample();
    checkOutput("to_req_issue", 32'(data_req), 32'd1);
    checkOutput("to_hold_issue", 32'(hold), 32'd1);
    for (int i = 0; i < 4; i++) begin
      toDrive();
      toSample();
      checkOutput("to_req_wait", 32'(data_req), 32'd1);
      checkOutput("to_hold_wait", 32'(hold), 32'd1);
    end
    toDrive();
    toSample();
    checkOutput("to_req_drop", 32'(data_req), 32'd0);
    checkOutput("to_hold_release", 32'(hold), 32'd0);
    toDrive();
    toSample();
    checkOutput("to_exc_valid", 32'(exc_valid), 32'd1);
    checkOutput("to_exc_cause", 32'(exc_cause), 32'd2);
    checkOutput("to_exc_pc", exc_pc, 32'h1010);
    checkOutput("to_exc_tval", exc_tval, 32'h300);
    checkOutput("to_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("to_wb_rd_we", 32'(wb_rd_we), 32'd0);
    toDrive();
    data_rvalid = 1'b1;
    data_rdata  = 32'hDEAD_0000;
    toSample();
    toDrive();
    data_rvalid = 1'b0;
    toSample();
    checkOutput("stray_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("stray_exc_valid", 32'(exc_valid), 32'd0);
    checkOutput("stray_hold", 32'(hold), 32'd0);

    $display("[TB] LW 0x101 misaligned");
    toDrive();
    applyStimulus(1'b1, 4'd3, 32'h101, 32'h0, 5'd7, 1'b1, 32'h1014);
`ifdef MEM_MISALIGN_TRAP_EN
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    toSample();
    checkOutput("mis_req", 32'(data_req), 32'd0);
    checkOutput("mis_hold", 32'(hold), 32'd0);
    toDrive();
    toSample();
    checkOutput("mis_exc_valid", 32'(exc_valid), 32'd1);
    checkOutput("mis_exc_cause", 32'(exc_cause), 32'd0);
    checkOutput("mis_exc_tval", exc_tval, 32'h101);
    checkOutput("mis_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("mis_wb_rd_we", 32'(wb_rd_we), 32'd0);
`else
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    data_gnt = 1'b1;
    toSample();
    checkOutput("mis_req", 32'(data_req), 32'd1);
    checkOutput("mis_addr", data_addr, 32'h100);
    checkOutput("mis_hold", 32'(hold), 32'd1);
    toDrive();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h1234_5678;
    toSample();
    checkOutput("mis_hold_rvalid", 32'(hold), 32'd0);
    toDrive();
    data_rvalid = 1'b0;
    toSample();
    checkOutput("mis_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("mis_wb_wdata", wb_wdata, 32'h1234_5678);
    checkOutput("mis_wb_rd_we", 32'(wb_rd_we), 32'd1);
    checkOutput("mis_exc_valid", 32'(exc_valid), 32'd0);
`endif

    $display("[TB] reset while waiting for rvalid, then ADD");
    toDrive();
    applyStimulus(1'b1, 4'd3, 32'h400, 32'h0, 5'd8, 1'b1, 32'h1018);
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    data_gnt = 1'b1;
    toSample();
    checkOutput("rstmid_req_issue", 32'(data_req), 32'd1);
    toDrive();
    data_gnt = 1'b0;
    toSample();
    checkOutput("rstmid_hold_wait", 32'(hold), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_req", 32'(data_req), 32'd0);
    checkOutput("rstmid_hold", 32'(hold), 32'd0);
    checkOutput("rstmid_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rstmid_exc_valid", 32'(exc_valid), 32'd0);
    toDrive();
    toDrive();
    rst = 1'b0;
    applyStimulus(1'b1, 4'd0, 32'd7, 32'h0, 5'd5, 1'b1, 32'h101C);
    toDrive();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
    toSample();
    checkOutput("add_hold", 32'(hold), 32'd0);
    checkOutput("add_req", 32'(data_req), 32'd0);
    toDrive();
    toSample();
    checkOutput("add_wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("add_wb_wdata", wb_wdata, 32'd7);
    checkOutput("add_wb_rd", 32'(wb_rd_addr), 32'd5);
    checkOutput("add_wb_rd_we", 32'(wb_rd_we), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between ex_stage and wb_stage.
- Registers the EX result and performs LB/LH/LW/LBU/LHU/SB/SH/SW over a req/gnt/rvalid data bus.
- Aligns and extends load data, and forwards the write-back packet to wb_stage.
- Raises hold to ctrl while an access is outstanding, and reports misaligned/timeout exceptions.

Parameters:
TIMEOUT_CYC, 255, max cycles waiting for gnt or rvalid before a bus-timeout exception; 0 disables the timeout counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
ex_valid_i  in  1  EX presents an instruction
ex_mem_op_i  in  4  mem_op_t encoding
ex_alu_result_i  in  32  effective address, or ALU result for non-mem ops
ex_wdata_i  in  32  store data (rs2)
ex_rd_addr_i  in  5  destination register
ex_rd_we_i  in  1  destination write enable
ex_pc_i  in  32  instruction PC
hold_o  out  1  stall request to ctrl; EX must hold its outputs
data_req_o  out  1  bus request
data_we_o  out  1  1 = store
data_be_o  out  4  byte enables
data_addr_o  out  32  word-aligned address
data_wdata_o  out  32  lane-replicated store data
data_gnt_i  in  1  request accepted
data_rvalid_i  in  1  load data valid
data_rdata_i  in  32  load data
wb_valid_o  out  1  write-back packet valid
wb_rd_addr_o  out  5  destination
wb_rd_we_o  out  1  write enable
wb_wdata_o  out  32  write-back data
exc_valid_o  out  1  exception pulse
exc_cause_o  out  2  0 load-misalign, 1 store-misalign, 2 load-timeout, 3 store-timeout
exc_pc_o  out  32  faulting PC
exc_tval_o  out  32  faulting address

Behaviour:
- Reset: all outputs 0; FSM IDLE; stage register empty; timeout counter 0.
- Stage register loads the EX inputs on a rising edge when hold_o=0. When ex_valid_i=0 it loads a bubble.
- done (combinational) = occupied AND any of:
  - op NONE
  - store with gnt
  - load with rvalid
  - exception this cycle
- hold_o = occupied AND NOT done.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
  - IDLE with a mem op: drive data_req_o=1 in the same cycle the register is occupied. If gnt arrives that cycle: load goes to WAIT_RVALID, store completes. Otherwise go to WAIT_GNT.
  - WAIT_GNT: hold data_req_o and all data_* outputs stable until gnt. Then load goes to WAIT_RVALID; store goes to IDLE.
  - WAIT_RVALID: data_req_o=0. rvalid returns to IDLE.
  - gnt and rvalid in the same cycle as a load request is illegal on this bus (rvalid is at least 1 cycle after gnt).
- Non-mem op: single cycle; wb_wdata_o = alu result.
- Write-back outputs are registered: 1 cycle after done, wb_valid_o=1 for exactly one cycle per instruction.
- Stores: wb_rd_we_o=0.
- Load extension: select lane by addr[1:0].
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
- Store encoding: data_be_o is
  - SB: 0001<<addr[1:0]
  - SH: 0011<<addr[1:0]
  - SW: 1111
  - data_wdata_o replicates the byte or half across lanes.
  - data_addr_o = {addr[31:2],2'b00}.
- Timeout counter: cleared on each state entry, increments in WAIT_GNT/WAIT_RVALID. When it equals TIMEOUT_CYC:
  - raise the timeout exception;
  - return to IDLE, dropping data_req_o;
  - ignore a later stray rvalid while in IDLE.
- Exception: exc_valid_o and wb_valid_o pulse together with wb_rd_we_o=0 and exc_pc_o/exc_tval_o set.
- Reset mid-access: immediate IDLE with data_req_o=0. The bus is reset by the same rst_i.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: a halfword at addr[0]=1, or a word at addr[1:0]!=0, issues no bus request. It raises cause 0/1 in 1 cycle, with tval = unaligned address.
- Undefined: the address is force-aligned (low bits cleared per size) and the access proceeds normally; no misalign cause is ever produced.

Decomposition:
- Package mem_pkg holds:
  - mem_op_t: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8;
  - exception-cause constants;
  - FSM state enum.
- Sub-module lsu_align (combinational): byte-enable/store-lane generation and load extraction/extension. Shared by the verification model.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle -> be=1111, addr 0x100, hold_o=0, wb_valid 1 cycle later, rd_we=0.
- LB addr 0x203, gnt after 2 cycles, rvalid 1 cycle later with rdata 0x80FF_0000 -> hold_o high 3 cycles, wb_wdata 0xFFFFFF80.
- LHU addr 0x202, rdata 0x8001_1234 -> wb_wdata 0x00008001; SH addr 0x202 data 0xABCD -> be=1100, wdata 0xABCDABCD.
- With TIMEOUT_CYC=4, LW with gnt never asserted -> exc_valid cause 2 after 4 wait cycles, data_req_o drops, hold_o released.
- LW addr 0x101 -> with MEM_MISALIGN_TRAP_EN: cause 0, tval 0x101, no data_req_o; without it: access at 0x100, normal load.
- rst_i asserted in WAIT_RVALID -> outputs 0 and FSM IDLE immediately; next ADD (op NONE, result 7, rd 5) completes with wb_wdata 7.
